mc_acc_cpu: RTL



---
 rtl/mc_acc_cpu.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mc_acc_cpu.sv
// Multi-cycle accumulator CPU core: two-word fetch and data access over
// req/ack handshakes, parametrised width and register count.
module mc_acc_cpu #(
  parameter int WIDTH = 8,
  parameter int NREGS = 8,
  parameter int RSEL  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] port,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_instr,
  input  logic [WIDTH-1:0] imem_arg,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [WIDTH-1:0] dmem_addr,
  output logic [WIDTH-1:0] dmem_wdata,
  input  logic             dmem_ack,
  input  logic [WIDTH-1:0] dmem_rdata,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] acc,
  output logic             flag_z,
  output logic             flag_c,
  output logic             halted
);

  // state   | meaning
  // S_IDLE  | one cycle after reset before the first fetch
  // S_FETCH | imem request held until imem_ack, then instr/arg latched
  // S_EXEC  | execute latched instruction
  // S_MEM   | dmem request held until dmem_ack (LD/ST)
  // S_HALT  | stopped, left only through reset
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [WIDTH-1:0] instr_q, arg_q, lr;
  logic [WIDTH-1:0] pc_nxt, acc_nxt, lr_nxt, pc_inc, r_val;
  logic             z_nxt, c_nxt, reg_we, acc_wr;
  logic [3:0]       opcode;
  logic [RSEL-1:0]  sel;
  logic [WIDTH:0]   add_r, add_i, sub_r;
  logic [WIDTH-1:0] regs [NREGS];

  assign opcode = instr_q[3:0];
  assign sel    = arg_q[RSEL-1:0];
  assign r_val  = (sel == '0) ? port : regs[sel];
  assign pc_inc = pc + ONE;
  assign add_r  = {1'b0, acc} + {1'b0, r_val};
  assign add_i  = {1'b0, acc} + {1'b0, arg_q};
  // MSB of the widened difference is the borrow (acc < r)
  assign sub_r  = {1'b0, acc} - {1'b0, r_val};

  assign imem_req   = (state == S_FETCH);
  assign imem_addr  = pc;
  assign dmem_req   = (state == S_MEM);
  assign dmem_we    = (state == S_MEM) && (opcode == 4'h3);
  assign dmem_addr  = arg_q;
  assign dmem_wdata = acc;
  assign halted     = (state == S_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    acc_nxt   = acc;
    lr_nxt    = lr;
    z_nxt     = flag_z;
    c_nxt     = flag_c;
    reg_we    = 1'b0;
    acc_wr    = 1'b0;
    case (state)
      S_IDLE:  state_nxt = S_FETCH;
      S_FETCH: if (imem_ack) state_nxt = S_EXEC;
      S_EXEC: begin
        state_nxt = S_FETCH;
        pc_nxt    = pc_inc;
        case (opcode)
          4'h1: begin acc_nxt = arg_q; acc_wr = 1'b1; end
          4'h2, 4'h3: state_nxt = S_MEM;
          4'h4: begin acc_nxt = add_r[WIDTH-1:0]; c_nxt = add_r[WIDTH]; acc_wr = 1'b1; end
          4'h5: begin acc_nxt = sub_r[WIDTH-1:0]; c_nxt = sub_r[WIDTH]; acc_wr = 1'b1; end
          4'h6: begin acc_nxt = acc & r_val; acc_wr = 1'b1; end
          4'h7: begin acc_nxt = acc | r_val; acc_wr = 1'b1; end
          4'h8: begin acc_nxt = acc ^ r_val; acc_wr = 1'b1; end
          4'h9: begin acc_nxt = add_i[WIDTH-1:0]; c_nxt = add_i[WIDTH]; acc_wr = 1'b1; end
          4'hA: pc_nxt = arg_q;
          4'hB: pc_nxt = flag_z ? arg_q : pc_inc;
          4'hC: begin lr_nxt = pc_inc; pc_nxt = arg_q; end
          4'hD: pc_nxt = lr;
          4'hE: reg_we = (sel != '0);
          4'hF: begin pc_nxt = pc; state_nxt = S_HALT; end
          default: ;
        endcase
      end
      S_MEM: begin
        if (dmem_ack) begin
          state_nxt = S_FETCH;
          if (opcode == 4'h2) begin
            acc_nxt = dmem_rdata;
            acc_wr  = 1'b1;
          end
        end
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
    if (acc_wr) z_nxt = (acc_nxt == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= '0;
      acc     <= '0;
      lr      <= '0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
      instr_q <= '0;
      arg_q   <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      pc     <= pc_nxt;
      acc    <= acc_nxt;
      lr     <= lr_nxt;
      flag_z <= z_nxt;
      flag_c <= c_nxt;
      if (state == S_FETCH && imem_ack) begin
        instr_q <= imem_instr;
        arg_q   <= imem_arg;
      end
      if (reg_we) regs[sel] <= acc;
    end
  end

endmodule
